jk_bank_ctrl: RTL and testbench
===============================

# jk_bank_ctrl

Command-driven controller that sequences a bank of WIDTH JK flip-flops. It accepts one command at a time over a valid/ready handshake and derives per-bit J/K drive from the JK excitation rule. Supported commands are set, clear, toggle, load, and multi-step up/down counting. It sits between a host sequencer or testbench and the JK storage bank, exposing the bank state on q.

## Interface
- WIDTH, 4, number of JK cells in the bank
- CNT_W, 8, width of the step-count field for count commands
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command; high only in IDLE
- cmd_op  in  3  opcode: 0 NOP, 1 SET, 2 CLEAR, 3 TOGGLE, 4 LOAD, 5 UP, 6 DOWN, 7 reserved (executes as NOP)
- cmd_data  in  WIDTH  LOAD target value
- cmd_count  in  CNT_W  step count for UP/DOWN
- j_drv  out  WIDTH  J inputs presented to the bank
- k_drv  out  WIDTH  K inputs presented to the bank
- q  out  WIDTH  bank state
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on command completion

## Operation
- Clocking: one clock; reset is synchronous and active-high.
- Reset values: q=0, j_drv=0, k_drv=0, busy=0, done=0. State is IDLE, so cmd_ready=1 in the first cycle after rst is released.
- Handshake:
  - A command is accepted on the rising edge where cmd_valid & cmd_ready.
  - cmd_op, cmd_data, and cmd_count are captured into registers at that edge.
  - cmd_valid while busy is ignored. There is no queue and no error signal.
- States:
  - IDLE: j/k=0; goes to EXEC on accepting a single-step op (NOP, SET, CLEAR, TOGGLE, LOAD, reserved).
  - IDLE goes to COUNT on accepting UP/DOWN with cmd_count>0.
  - IDLE goes directly to DONE on accepting UP/DOWN with cmd_count=0; q is unchanged.
  - EXEC: drives j/k for exactly one cycle, then goes to DONE.
  - COUNT: drives j/k every cycle and decrements the step register; after the last step it goes to DONE.
  - DONE: j/k=0, done=1 for one cycle, then returns to IDLE.
- Excitation rule, applied uniformly for every op:
  - Compute the target state nxt, then j_drv = nxt & ~q and k_drv = ~nxt & q.
  - Unchanged bits get J=K=0 (hold). Toggling bits get exactly one of J/K asserted.
- Targets:
  - SET: all ones. CLEAR: all zeros. TOGGLE: ~q. LOAD: cmd_data. NOP: q.
  - UP: q+1 mod 2^WIDTH. DOWN: q-1 mod 2^WIDTH.
- Arithmetic is WIDTH bits with wrap-around: UP from all-ones gives 0; DOWN from 0 gives all-ones.
- Reset mid-command aborts the command: q is cleared and state returns to IDLE, with no done pulse.

## Timing
- Single-step op accepted at edge E0:
  - Cycle E0..E1 is EXEC, with j/k valid.
  - q takes the new value at E1.
  - done=1 during E1..E2.
  - cmd_ready=1 from E2.
  - Throughput is one command per 3 cycles.
- UP/DOWN with n>0 accepted at E0:
  - COUNT occupies n cycles; q advances by one at each of E1..En.
  - done=1 during En..En+1; cmd_ready=1 from En+1.
- UP/DOWN with n=0: done=1 during E0..E1; cmd_ready=1 from E1.
- j_drv/k_drv are computed combinationally from state, the captured op, and the current q. The bank samples them at the next edge.
- done, busy, and cmd_ready have no combinational path from cmd_valid.

## Structure
- Package jk_ctrl_pkg holds:
  - the opcode constants (OP_NOP…OP_DOWN) and the 3-bit opcode type;
  - the state enum (IDLE, EXEC, COUNT, DONE).
- Sub-module jk_cell: a single JK flip-flop with synchronous active-high reset and a q/qbar pair, instantiated WIDTH times in a generate loop. qbar is left unused.
- The controller holds the FSM, the captured command registers, the CNT_W step counter, and the excitation logic.

## Test plan
All scenarios use WIDTH=4.
- Reset: hold rst 2 cycles, then release -> q=0, busy=0, done=0, cmd_ready=1, j_drv=k_drv=0.
- LOAD 4'b1010 from q=0 -> during EXEC j_drv=1010, k_drv=0000; q=1010 next edge; done pulses once; cmd_ready returns after 3 cycles total.
- TOGGLE from 1010 -> j_drv=0101, k_drv=1010, q=0101. SET from 0101 -> j_drv=1010, k_drv=0000, q=1111.
- UP count=3 from q=1110 -> q sequence 1111, 0000, 0001 (wrap); done one cycle after the last step. DOWN count=2 from 0001 -> 0000, 1111.
- UP count=0 and opcode 7 -> q unchanged, done pulses; cmd_valid held high while busy -> no second acceptance until cmd_ready is high.
- Assert rst during step 2 of UP count=5 -> next edge q=0, state IDLE, no done pulse; a new LOAD is accepted on the following cycle.

Source files
------------

// File: rtl/jk_bank_ctrl_pkg.sv
// rtl/jk_bank_ctrl_pkg.sv - opcode and FSM state types for the JK bank controller
package jk_ctrl_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP    = 3'd0;
    localparam op_t OP_SET    = 3'd1;
    localparam op_t OP_CLEAR  = 3'd2;
    localparam op_t OP_TOGGLE = 3'd3;
    localparam op_t OP_LOAD   = 3'd4;
    localparam op_t OP_UP     = 3'd5;
    localparam op_t OP_DOWN   = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// rtl/jk_bank_ctrl_if.sv - command handshake and bank observation bus
interface jk_bank_ctrl_if
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] j_drv;
    logic [WIDTH-1:0] k_drv;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count,
        input  cmd_ready, j_drv, k_drv, q, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count,
        output cmd_ready, j_drv, k_drv, q, busy, done
    );

endinterface

// File: rtl/jk_bank_ctrl_cell.sv
// rtl/jk_bank_ctrl_cell.sv - single JK flip-flop with synchronous active-high reset
module jk_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o,
    output logic qbar_o
);
    logic q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= 1'b0;
        end else begin
            case ({j_i, k_i})
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o    = q_q;
    assign qbar_o = ~q_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - command FSM driving a bank of JK cells via the excitation rule
module jk_bank_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    jk_bank_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_w, nxt, j_w, k_w;
    logic [WIDTH-1:0] unused_qbar;
    logic             ready_w, done_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Target state of the bank for the captured op; reserved codes hold like NOP.
    always_comb begin
        nxt = q_w;
        case (op_q)
            OP_SET:    nxt = '1;
            OP_CLEAR:  nxt = '0;
            OP_TOGGLE: nxt = ~q_w;
            OP_LOAD:   nxt = data_q;
            OP_UP:     nxt = q_w + WIDTH'(1);
            OP_DOWN:   nxt = q_w - WIDTH'(1);
            default:   nxt = q_w;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        j_w     = '0;
        k_w     = '0;
        ready_w = 1'b0;
        done_w  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_w = 1'b1;
                if (bus.cmd_valid) begin
                    op_d   = bus.cmd_op;
                    data_d = bus.cmd_data;
                    cnt_d  = bus.cmd_count;
                    if (bus.cmd_op == OP_UP || bus.cmd_op == OP_DOWN) begin
                        state_d = (bus.cmd_count == '0) ? DONE : COUNT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                j_w     = nxt & ~q_w;
                k_w     = ~nxt & q_w;
                state_d = DONE;
            end
            COUNT: begin
                j_w   = nxt & ~q_w;
                k_w   = ~nxt & q_w;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_w  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk_i  (clk),
            .rst_i  (rst),
            .j_i    (j_w[i]),
            .k_i    (k_w[i]),
            .q_o    (q_w[i]),
            .qbar_o (unused_qbar[i])
        );
    end

    assign bus.cmd_ready = ready_w;
    assign bus.done      = done_w;
    assign bus.busy      = (state_q != IDLE);
    assign bus.j_drv     = j_w;
    assign bus.k_drv     = k_w;
    assign bus.q         = q_w;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb/tb_jk_bank_ctrl.sv - directed self-checking bench for jk_bank_ctrl
module tb_jk_bank_ctrl;
    import jk_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    jk_bank_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();

    jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input op_t op, input logic [3:0] d, input logic [7:0] n);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.cmd_count = n;
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] q_exp);
        chk({tag, "_q"},     32'(bus.q), 32'(q_exp));
        chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_done"},  32'(bus.done), 32'd0);
    endtask

    // Single-step op from IDLE: checks EXEC drive, q at E1 with done, idle at E2.
    task automatic single(input string tag, input op_t op, input logic [3:0] d,
                          input logic [3:0] j_exp, input logic [3:0] k_exp, input logic [3:0] q_exp);
        drive(1'b1, op, d, 8'd0);
        step();
        drive(1'b0, OP_NOP, 4'd0, 8'd0);
        chk({tag, "_j"},      32'(bus.j_drv), 32'(j_exp));
        chk({tag, "_k"},      32'(bus.k_drv), 32'(k_exp));
        chk({tag, "_busy"},   32'(bus.busy), 32'd1);
        chk({tag, "_nready"}, 32'(bus.cmd_ready), 32'd0);
        step();
        chk({tag, "_qnew"},   32'(bus.q), 32'(q_exp));
        chk({tag, "_done"},   32'(bus.done), 32'd1);
        chk({tag, "_jdone"},  32'(bus.j_drv), 32'd0);
        step();
        chk_idle({tag, "_end"}, q_exp);
    endtask

    initial begin
        drive(1'b0, OP_NOP, 4'd0, 8'd0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk_idle("rst", 4'b0000);
        chk("rst_j", 32'(bus.j_drv), 32'd0);
        chk("rst_k", 32'(bus.k_drv), 32'd0);

        single("load",   OP_LOAD,   4'b1010, 4'b1010, 4'b0000, 4'b1010);
        single("toggle", OP_TOGGLE, 4'b0000, 4'b0101, 4'b1010, 4'b0101);
        single("set",    OP_SET,    4'b0000, 4'b1010, 4'b0000, 4'b1111);
        single("load2",  OP_LOAD,   4'b1110, 4'b0000, 4'b0001, 4'b1110);

        // UP 3 from 1110 wraps through 0000
        drive(1'b1, OP_UP, 4'd0, 8'd3);
        step();
        drive(1'b0, OP_NOP, 4'd0, 8'd0);
        chk("up_j0", 32'(bus.j_drv), 32'b0001);
        chk("up_k0", 32'(bus.k_drv), 32'b0000);
        step();
        chk("up_q1", 32'(bus.q), 32'b1111);
        chk("up_j1", 32'(bus.j_drv), 32'b0000);
        chk("up_k1", 32'(bus.k_drv), 32'b1111);
        chk("up_nd1", 32'(bus.done), 32'd0);
        step();
        chk("up_q2", 32'(bus.q), 32'b0000);
        chk("up_nd2", 32'(bus.done), 32'd0);
        step();
        chk("up_q3", 32'(bus.q), 32'b0001);
        chk("up_done", 32'(bus.done), 32'd1);
        step();
        chk_idle("up_end", 4'b0001);

        // DOWN 2 from 0001 wraps to 1111
        drive(1'b1, OP_DOWN, 4'd0, 8'd2);
        step();
        drive(1'b0, OP_NOP, 4'd0, 8'd0);
        chk("dn_k0", 32'(bus.k_drv), 32'b0001);
        step();
        chk("dn_q1", 32'(bus.q), 32'b0000);
        chk("dn_j1", 32'(bus.j_drv), 32'b1111);
        step();
        chk("dn_q2", 32'(bus.q), 32'b1111);
        chk("dn_done", 32'(bus.done), 32'd1);
        step();
        chk_idle("dn_end", 4'b1111);

        // UP with zero count goes straight to DONE
        drive(1'b1, OP_UP, 4'd0, 8'd0);
        step();
        drive(1'b0, OP_NOP, 4'd0, 8'd0);
        chk("up0_done", 32'(bus.done), 32'd1);
        chk("up0_busy", 32'(bus.busy), 32'd1);
        chk("up0_q", 32'(bus.q), 32'b1111);
        chk("up0_j", 32'(bus.j_drv), 32'd0);
        step();
        chk_idle("up0_end", 4'b1111);

        single("rsvd", op_t'(3'd7), 4'b0000, 4'b0000, 4'b0000, 4'b1111);

        // cmd_valid held through busy: second command waits for cmd_ready
        drive(1'b1, OP_LOAD, 4'b0011, 8'd0);
        step();
        drive(1'b1, OP_LOAD, 4'b0101, 8'd0);
        chk("hold_j0", 32'(bus.j_drv), 32'b0000);
        chk("hold_k0", 32'(bus.k_drv), 32'b1100);
        step();
        chk("hold_q1", 32'(bus.q), 32'b0011);
        chk("hold_done1", 32'(bus.done), 32'd1);
        step();
        chk("hold_ready", 32'(bus.cmd_ready), 32'd1);
        chk("hold_busy2", 32'(bus.busy), 32'd0);
        chk("hold_q2", 32'(bus.q), 32'b0011);
        step();
        drive(1'b0, OP_NOP, 4'd0, 8'd0);
        chk("hold2_busy", 32'(bus.busy), 32'd1);
        chk("hold2_j", 32'(bus.j_drv), 32'b0100);
        chk("hold2_k", 32'(bus.k_drv), 32'b0010);
        step();
        chk("hold2_q", 32'(bus.q), 32'b0101);
        chk("hold2_done", 32'(bus.done), 32'd1);
        step();
        chk_idle("hold2_end", 4'b0101);

        // Reset during step 2 of UP 5 aborts without done
        drive(1'b1, OP_UP, 4'd0, 8'd5);
        step();
        drive(1'b0, OP_NOP, 4'd0, 8'd0);
        step();
        chk("abort_q1", 32'(bus.q), 32'b0110);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("abort", 4'b0000);
        chk("abort_j", 32'(bus.j_drv), 32'd0);
        single("post", OP_LOAD, 4'b1001, 4'b1001, 4'b0000, 4'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
